aes_decipher_sequencer: RTL and testbench
=========================================

AES_DECIPHER_SEQUENCER -- requirements
Module: aes_decipher_sequencer

Interface
REQ-001 SHALL have parameter AES_128_ROUNDS, default 10, number of rounds for keylen=0.
REQ-002 SHALL have parameter AES_256_ROUNDS, default 14, number of rounds for keylen=1.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port keylen  input  1  key length; 0=AES-128, 1=AES-256; sampled only when a block is accepted.
REQ-006 SHALL have port next  input  1  start request; a single-cycle pulse is sufficient.
REQ-007 SHALL have port ready  output  1  high when idle and able to accept next.
REQ-008 SHALL have port block  input  128  ciphertext; sampled only when a block is accepted.
REQ-009 SHALL have port round  output  4  round-key index to the key memory.
REQ-010 SHALL have port round_key  input  128  key for the current round; combinational return for the current round value.
REQ-011 SHALL have port round_type  output  2  round code to the decipher round: 0=INIT, 1=MAIN, 2=FINAL.
REQ-012 SHALL have port state_out  output  128  current state to the decipher round, s00 in [127:120] through s33 in [7:0].
REQ-013 SHALL have port new_state  input  128  decipher-round result, same packing as state_out.
REQ-014 SHALL have port result  output  128  plaintext; equals the state register.
REQ-015 SHALL have port result_valid  output  1  high while result holds a completed block.

Function
REQ-016 SHALL implement FSM states IDLE, INIT, MAIN and FINAL.
REQ-017 SHALL accept a block only in IDLE with next=1; ready SHALL equal (fsm==IDLE).
REQ-018 On acceptance, the block SHALL do all of the following: state_reg<=block; nr<=(keylen ? AES_256_ROUNDS : AES_128_ROUNDS); round_ctr<=that nr; result_valid<=0; FSM->INIT.
REQ-019 In INIT, the block SHALL drive round_type=0 and round=nr, and SHALL apply state_reg<=new_state, round_ctr<=nr-1, FSM->MAIN.
REQ-020 In MAIN, the block SHALL drive round_type=1 and round=round_ctr, apply state_reg<=new_state and round_ctr<=round_ctr-1, and go to FINAL when round_ctr==1, otherwise stay in MAIN.
REQ-021 In FINAL, the block SHALL drive round_type=2 and round=0, apply state_reg<=new_state and result_valid<=1, FSM->IDLE.
REQ-022 In IDLE, the block SHALL drive round_type=0 and round=0, and SHALL hold state_reg.
REQ-023 state_out SHALL equal state_reg in every state; round_ctr decrements SHALL never wrap below 0.
REQ-024 Latency: if next is accepted at edge E0, result_valid SHALL rise at edge E0+nr+1 (11 cycles for AES-128, 15 for AES-256); MAIN SHALL occupy exactly nr-1 cycles.
REQ-025 next asserted while not in IDLE SHALL be ignored, with no queuing and no effect on the current operation.
REQ-026 next asserted in the same cycle FINAL completes SHALL be ignored; it is accepted only from IDLE on a following cycle.
REQ-027 Changes to keylen or block during an operation SHALL have no effect on it.
REQ-028 result_valid SHALL stay high until the next accepted block.

Reset
REQ-029 reset_n=0 SHALL immediately force: FSM=IDLE, state_reg=0, round_ctr=0, nr=AES_128_ROUNDS, result_valid=0, ready=1, round_type=0, round=0.
REQ-030 Reset asserted mid-operation SHALL abort the operation with no result_valid pulse; the first next after release SHALL be accepted normally.

Verification
REQ-031 Stub-round scenario: bench stub new_state=state_out^round_key with round_key={16{4'h0,round}}; keylen=0, block=0, pulse next -> round sequence 10,9,...,1,0 with round_type 0,1x9,2; result_valid at the 11th edge; result equals the XOR of the stub keys.
REQ-032 AES-256 scenario: same stub with keylen=1 -> round sequence 14..0, 13 MAIN cycles, result_valid at the 15th edge, ready low for exactly 15 cycles.
REQ-033 Busy-ignore scenario: pulse next with a different block and keylen=1 at cycle 5 of an AES-128 run -> sequence unchanged, result from the original block only.
REQ-034 Back-to-back scenario: hold next=1 continuously -> blocks accepted only from IDLE, one idle cycle between runs; result_valid drops on each acceptance.
REQ-035 Mid-operation reset scenario: assert reset_n=0 at cycle 6 of a run -> all outputs at reset values asynchronously, no result_valid; a new run after release completes in 11 cycles.
REQ-036 Integration scenario: real decipher round plus equivalent-inverse key schedule, FIPS-197 C.1 ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a, key 000102030405060708090a0b0c0d0e0f -> result 00112233445566778899aabbccddeeff.

Source files
------------

// File: rtl/aes_decipher_sequencer.sv
// -----------------------------------------------------------------------------
// aes_decipher_sequencer
//
// Round sequencer for an iterative AES decipher datapath. It does not compute
// any AES transformation itself. Instead it holds the 128-bit state, tells an
// external decipher round which round key and which round flavour to apply,
// and writes the round result back into the state register once per cycle.
//
// Sequence for one block (nr = 10 for AES-128, 14 for AES-256):
//   INIT  (1 cycle)       round = nr,           round_type = INIT
//   MAIN  (nr-1 cycles)   round = nr-1 .. 1,    round_type = MAIN
//   FINAL (1 cycle)       round = 0,            round_type = FINAL
// When a block is accepted at clock edge E0, result_valid rises at edge E0+nr+1.
//
// Ports
//   clk           sole clock; all state changes on the rising edge
//   reset_n       asynchronous, active-low reset
//   keylen        0 = AES-128, 1 = AES-256; sampled when a block is accepted
//   next          start request; accepted only while ready is high
//   ready         high while idle and able to accept next
//   block         ciphertext; sampled when a block is accepted
//   round         round-key index presented to the key memory
//   round_key     key for the current round (consumed by the external round)
//   round_type    0 = INIT, 1 = MAIN, 2 = FINAL
//   state_out     current state, s00 in [127:120] .. s33 in [7:0]
//   new_state     result of the external decipher round, same packing
//   result        plaintext; always equal to the state register
//   result_valid  high while result holds a completed block
// -----------------------------------------------------------------------------
module aes_decipher_sequencer #(
  parameter int AES_128_ROUNDS = 10,
  parameter int AES_256_ROUNDS = 14
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         keylen,
  input  logic         next,
  output logic         ready,
  input  logic [127:0] block,
  output logic [3:0]   round,
  input  logic [127:0] round_key,
  output logic [1:0]   round_type,
  output logic [127:0] state_out,
  input  logic [127:0] new_state,
  output logic [127:0] result,
  output logic         result_valid
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_INIT  = 2'd1,
    S_MAIN  = 2'd2,
    S_FINAL = 2'd3
  } fsm_t;

  localparam logic [1:0] RT_INIT  = 2'd0;
  localparam logic [1:0] RT_MAIN  = 2'd1;
  localparam logic [1:0] RT_FINAL = 2'd2;

  localparam logic [3:0] NR_128 = 4'(AES_128_ROUNDS);
  localparam logic [3:0] NR_256 = 4'(AES_256_ROUNDS);

  fsm_t         r_fsm;
  logic [127:0] r_state;
  logic [3:0]   r_nr;
  logic [3:0]   r_round_ctr;
  logic [3:0]   r_round;
  logic [1:0]   r_round_type;
  logic         r_result_valid;

  logic [3:0]   w_nr_sel;
  logic [3:0]   w_nr_m1;
  logic [3:0]   w_ctr_m1;
  logic         w_unused_round_key;

  assign w_nr_sel = keylen ? NR_256 : NR_128;

  // Saturating decrements: the round counter must never wrap below zero.
  assign w_nr_m1  = (r_nr == 4'd0)        ? 4'd0 : r_nr - 4'd1;
  assign w_ctr_m1 = (r_round_ctr == 4'd0) ? 4'd0 : r_round_ctr - 4'd1;

  // The round key is consumed by the external decipher round; the sequencer
  // only forms the index that selects it.
  assign w_unused_round_key = ^round_key;

  // NOTE: round and round_type are registered alongside the FSM, so each
  // transition loads the values the *next* state must present. They are then
  // stable for the whole cycle and free of decode glitches.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fsm          <= S_IDLE;
      r_state        <= '0;
      r_nr           <= NR_128;
      r_round_ctr    <= 4'd0;
      r_round        <= 4'd0;
      r_round_type   <= RT_INIT;
      r_result_valid <= 1'b0;
    end else begin
      case (r_fsm)
        S_IDLE: begin
          // keylen and block are captured only here, so changing them while
          // a block is in flight cannot disturb it.
          if (next) begin
            r_state        <= block;
            r_nr           <= w_nr_sel;
            r_round_ctr    <= w_nr_sel;
            r_result_valid <= 1'b0;
            r_round        <= w_nr_sel;
            r_round_type   <= RT_INIT;
            r_fsm          <= S_INIT;
          end
        end

        S_INIT: begin
          r_state      <= new_state;
          r_round_ctr  <= w_nr_m1;
          r_round      <= w_nr_m1;
          r_round_type <= RT_MAIN;
          r_fsm        <= S_MAIN;
        end

        S_MAIN: begin
          r_state     <= new_state;
          r_round_ctr <= w_ctr_m1;
          // "<= 1" rather than "== 1" so a degenerate round count can never
          // strand the FSM in MAIN.
          if (r_round_ctr <= 4'd1) begin
            r_round      <= 4'd0;
            r_round_type <= RT_FINAL;
            r_fsm        <= S_FINAL;
          end else begin
            r_round      <= w_ctr_m1;
            r_round_type <= RT_MAIN;
          end
        end

        S_FINAL: begin
          // A next seen in this cycle is ignored: acceptance is decoded only
          // in IDLE, which is reached at the end of this cycle.
          r_state        <= new_state;
          r_result_valid <= 1'b1;
          r_round        <= 4'd0;
          r_round_type   <= RT_INIT;
          r_fsm          <= S_IDLE;
        end

        default: r_fsm <= S_IDLE;
      endcase
    end
  end

  assign ready        = (r_fsm == S_IDLE);
  assign round        = r_round;
  assign round_type   = r_round_type;
  assign state_out    = r_state;
  assign result       = r_state;
  assign result_valid = r_result_valid;

endmodule

// File: tb/tb_aes_decipher_sequencer.sv
// -----------------------------------------------------------------------------
// tb_aes_decipher_sequencer
//
// Self-checking bench for aes_decipher_sequencer. The external decipher round
// is modelled here in two flavours: an XOR stub (new_state = state ^ key with
// key = {16{4'h0, round}}) and a real AES inverse round driven by an
// equivalent-inverse key schedule, for a known-answer check against FIPS-197.
// Expected plaintexts go into a scoreboard queue when a block is started and
// are popped when result_valid rises.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_aes_decipher_sequencer;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         keylen;
  logic         next;
  logic         ready;
  logic [127:0] block;
  logic [3:0]   round;
  logic [127:0] round_key;
  logic [1:0]   round_type;
  logic [127:0] state_out;
  logic [127:0] new_state;
  logic [127:0] result;
  logic         result_valid;

  always #5 clk = ~clk;

  aes_decipher_sequencer #(
    .AES_128_ROUNDS(10),
    .AES_256_ROUNDS(14)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .keylen      (keylen),
    .next        (next),
    .ready       (ready),
    .block       (block),
    .round       (round),
    .round_key   (round_key),
    .round_type  (round_type),
    .state_out   (state_out),
    .new_state   (new_state),
    .result      (result),
    .result_valid(result_valid)
  );

  int           n_total = 0;
  int           n_bad   = 0;
  logic [127:0] sb_q[$];
  logic [127:0] sb_exp;
  logic         prev_valid = 1'b0;
  bit           stub_mode  = 1'b1;
  logic [7:0]   sbox[256];
  logic [7:0]   inv_sbox[256];
  logic [127:0] key_tbl[16];

  typedef struct {
    logic         kl;
    logic [127:0] blk;
    int           busy_at;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // ---------------- GF(2^8) and AES inverse-round model ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    return 8'((x << n) | (x >> (8 - n)));
  endfunction

  // S-box from first principles: multiplicative inverse then affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] s;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gm(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      sbox[a]     = s;
      inv_sbox[s] = 8'(a);
    end
  endtask

  function automatic logic [127:0] inv_sub(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int k = 0; k < 16; k++) o[127-8*k -: 8] = inv_sbox[s[127-8*k -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] inv_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 32] = {
        gm(a0,8'h0e) ^ gm(a1,8'h0b) ^ gm(a2,8'h0d) ^ gm(a3,8'h09),
        gm(a0,8'h09) ^ gm(a1,8'h0e) ^ gm(a2,8'h0b) ^ gm(a3,8'h0d),
        gm(a0,8'h0d) ^ gm(a1,8'h09) ^ gm(a2,8'h0e) ^ gm(a3,8'h0b),
        gm(a0,8'h0b) ^ gm(a1,8'h0d) ^ gm(a2,8'h09) ^ gm(a3,8'h0e)};
    end
    return o;
  endfunction

  // AES-128 expansion, then the equivalent-inverse keys: InvMixColumns is
  // applied to the inner round keys 1..9.
  task automatic build_keys(input logic [127:0] key);
    logic [31:0] w[44];
    logic [31:0] t;
    logic [7:0]  rc;
    logic [127:0] rk;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 16; r++) key_tbl[r] = '0;
    for (int r = 0; r <= 10; r++) begin
      rk = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      key_tbl[r] = (r == 0 || r == 10) ? rk : inv_mix(rk);
    end
  endtask

  // External key memory and decipher round.
  always_comb begin
    round_key = '0;
    new_state = '0;
    if (stub_mode) begin
      round_key = {16{4'h0, round}};
      new_state = state_out ^ round_key;
    end else begin
      round_key = key_tbl[round];
      case (round_type)
        2'd1:    new_state = inv_mix(inv_shift(inv_sub(state_out))) ^ round_key;
        2'd2:    new_state = inv_shift(inv_sub(state_out)) ^ round_key;
        default: new_state = state_out ^ round_key;
      endcase
    end
  end

  function automatic logic [127:0] stub_expect(input logic kl, input logic [127:0] blk);
    logic [127:0] acc;
    int nr;
    acc = blk;
    nr  = kl ? 14 : 10;
    for (int r = 0; r <= nr; r++) acc ^= {16{4'h0, 4'(r)}};
    return acc;
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (result_valid === 1'b1 && prev_valid !== 1'b1) begin
      if (sb_q.size() == 0) begin
        n_total++;
        n_bad++;
        $display("FAIL unexpected result_valid: got result %h want no result", result);
      end else begin
        sb_exp = sb_q.pop_front();
        check("scoreboard result", result, sb_exp);
      end
    end
    prev_valid <= result_valid;
  end

  // One full block, started from IDLE at a negedge. busy_at >= 0 pulses next
  // with a different block and key length at that cycle of the run.
  task automatic run_vec(input string tag, input logic kl, input logic [127:0] blk,
                         input int busy_at, input logic [127:0] exp);
    int nr;
    logic [127:0] exp_state;
    nr = kl ? 14 : 10;
    check({tag, " ready before start"}, ready, 1);
    keylen = kl;
    block  = blk;
    next   = 1'b1;
    sb_q.push_back(exp);
    @(posedge clk);
    #1 next = 1'b0;
    exp_state = blk;
    for (int k = 0; k <= nr; k++) begin
      @(negedge clk);
      check($sformatf("%s k%0d round", tag, k), round, nr - k);
      check($sformatf("%s k%0d round_type", tag, k), round_type,
            (k == 0) ? 0 : (k == nr) ? 2 : 1);
      check($sformatf("%s k%0d ready", tag, k), ready, 0);
      check($sformatf("%s k%0d result_valid", tag, k), result_valid, 0);
      if (stub_mode) begin
        check($sformatf("%s k%0d state_out", tag, k), state_out, exp_state);
        exp_state ^= {16{4'h0, 4'(nr - k)}};
      end
      if (k == busy_at) begin
        next   = 1'b1;
        keylen = ~kl;
        block  = ~blk;
      end else if (k == busy_at + 1) begin
        next = 1'b0;
      end
    end
    @(negedge clk);
    check({tag, " result_valid at nr+1"}, result_valid, 1);
    check({tag, " ready after run"}, ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b1;
    keylen  = 1'b0;
    next    = 1'b0;
    block   = '0;
    build_sbox();

    vecs[0] = '{1'b0, 128'h0, -1, 128'h0};
    vecs[1] = '{1'b1, 128'h0, -1, 128'h0};
    vecs[2] = '{1'b0, 128'h0123456789abcdef_fedcba9876543210, 5, 128'h0};
    vecs[3] = '{1'b1, 128'hdeadbeef_cafef00d_12345678_9abcdef0, 3, 128'h0};
    vecs[4] = '{1'b0, {128{1'b1}}, -1, 128'h0};
    for (int i = 0; i < 5; i++) vecs[i].exp = stub_expect(vecs[i].kl, vecs[i].blk);

    // Asynchronous reset, checked before the first clock edge.
    #1 reset_n = 1'b0;
    #2;
    check("reset ready", ready, 1);
    check("reset result_valid", result_valid, 0);
    check("reset round", round, 0);
    check("reset round_type", round_type, 0);
    check("reset result", result, '0);
    check("reset state_out", state_out, '0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++)
      run_vec($sformatf("v%0d", i), vecs[i].kl, vecs[i].blk, vecs[i].busy_at, vecs[i].exp);

    // result_valid holds while idle.
    repeat (3) begin
      @(negedge clk);
      check("hold result_valid", result_valid, 1);
      check("hold result", result, vecs[4].exp);
    end

    // next held high: accepted only from IDLE, one idle cycle between runs.
    keylen = 1'b0;
    block  = 128'h00ff00ff_00ff00ff_11223344_55667788;
    next   = 1'b1;
    sb_q.push_back(stub_expect(1'b0, block));
    sb_q.push_back(stub_expect(1'b0, block));
    @(posedge clk);
    #1;
    for (int run = 0; run < 2; run++) begin
      for (int k = 0; k <= 10; k++) begin
        @(negedge clk);
        check($sformatf("b2b r%0d k%0d ready", run, k), ready, 0);
        check($sformatf("b2b r%0d k%0d result_valid", run, k), result_valid, 0);
        check($sformatf("b2b r%0d k%0d round", run, k), round, 10 - k);
      end
      @(negedge clk);
      check($sformatf("b2b r%0d idle ready", run), ready, 1);
      check($sformatf("b2b r%0d idle result_valid", run), result_valid, 1);
      if (run == 1) next = 1'b0;
    end
    @(negedge clk);

    // Reset in the middle of a run.
    keylen = 1'b0;
    block  = 128'h55555555_aaaaaaaa_33333333_cccccccc;
    next   = 1'b1;
    @(posedge clk);
    #1 next = 1'b0;
    for (int k = 0; k <= 6; k++) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("midrst ready", ready, 1);
    check("midrst result_valid", result_valid, 0);
    check("midrst round", round, 0);
    check("midrst round_type", round_type, 0);
    check("midrst result", result, '0);
    check("midrst state_out", state_out, '0);
    repeat (2) begin
      @(negedge clk);
      check("midrst held result_valid", result_valid, 0);
      check("midrst held ready", ready, 1);
    end
    reset_n = 1'b1;
    run_vec("postrst", 1'b0, 128'h0f0e0d0c_0b0a0908_07060504_03020100, -1,
            stub_expect(1'b0, 128'h0f0e0d0c_0b0a0908_07060504_03020100));

    // Known-answer test with a real inverse round (FIPS-197 C.1).
    build_keys(128'h000102030405060708090a0b0c0d0e0f);
    stub_mode = 1'b0;
    @(negedge clk);
    run_vec("fips", 1'b0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, -1,
            128'h00112233445566778899aabbccddeeff);
    check("fips result", result, 128'h00112233445566778899aabbccddeeff);

    @(negedge clk);
    check("scoreboard drained", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
